// File: rtl/dispatch_pkg.sv
// Shared types for the dual decode/dispatch stage: uop classes, execution units,
// RV32 opcode constants and the decoded-uop struct carried through the FIFO.
package dispatch_pkg;

  localparam int unsigned UOP_TAG_W = 6;

  typedef enum logic [1:0] {ClsAdd, ClsMul, ClsLoad, ClsStore} uop_class_e;
  typedef enum logic [1:0] {UnitAlu, UnitMulu, UnitMem} unit_e;

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [6:0]  F7_ADD    = 7'b0000000;
  localparam logic [6:0]  F7_MUL    = 7'b0000001;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  // Decoder output: a uop without its sequence tag.
  typedef struct packed {
    uop_class_e  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } dec_t;

  // Field order matches dec_t so that {dec, tag} packs directly into a uop_t.
  typedef struct packed {
    uop_class_e           cls;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [11:0]          imm;
    logic [UOP_TAG_W-1:0] tag;
  } uop_t;

  localparam int unsigned DEC_W = $bits(dec_t);
  localparam int unsigned UOP_W = $bits(uop_t);

  function automatic unit_e unit_of(uop_class_e c);
    unit_e u;
    unique case (c)
      ClsAdd:  u = UnitAlu;
      ClsMul:  u = UnitMulu;
      default: u = UnitMem;
    endcase
    return u;
  endfunction

  function automatic logic unit_ready(unit_e u, logic alu, logic mul, logic mem);
    logic r;
    unique case (u)
      UnitAlu:  r = alu;
      UnitMulu: r = mul;
      default:  r = mem;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32 subset decoder: ADD/MUL/LOAD/STORE are kept, the canonical
// NOP is dropped silently, anything else is dropped and flagged illegal.
module instr_decoder
  import dispatch_pkg::*;
(
  input  logic [31:0]      i_instr,
  output logic             o_keep,
  output logic             o_illegal,
  output logic [DEC_W-1:0] o_dec
);

  dec_t       w_dec;
  logic [6:0] w_opcode;
  logic [6:0] w_funct7;

  assign w_opcode = i_instr[6:0];
  assign w_funct7 = i_instr[31:25];
  assign o_dec    = w_dec;

  always_comb begin
    w_dec     = '0;
    o_keep    = 1'b0;
    o_illegal = 1'b0;
    w_dec.rd  = i_instr[11:7];
    w_dec.rs1 = i_instr[19:15];
    w_dec.rs2 = i_instr[24:20];
    if (i_instr != NOP_WORD) begin
      case (w_opcode)
        OPC_RTYPE: begin
          if (w_funct7 == F7_ADD) begin
            o_keep    = 1'b1;
            w_dec.cls = ClsAdd;
          end else if (w_funct7 == F7_MUL) begin
            o_keep    = 1'b1;
            w_dec.cls = ClsMul;
          end else begin
            o_illegal = 1'b1;
          end
        end
        OPC_LOAD: begin
          o_keep    = 1'b1;
          w_dec.cls = ClsLoad;
          w_dec.imm = i_instr[31:20];
        end
        OPC_STORE: begin
          o_keep    = 1'b1;
          w_dec.cls = ClsStore;
          w_dec.imm = {i_instr[31:25], i_instr[11:7]};
        end
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dual_decode_dispatch.sv
// Two-wide decode into an in-order uop FIFO with up-to-two in-order dispatch per cycle.
// Optional DISPATCH_STATS_EN adds saturating dual/single/stall cycle counters.
module dual_decode_dispatch
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction_in1,
  input  logic [31:0]      instruction_in2,
  input  logic             valid_in1,
  input  logic             valid_in2,
  input  logic             queue_empty_in,
  output logic             queue_advance,
  input  logic             alu_ready,
  input  logic             mul_ready,
  input  logic             mem_ready,
  output logic             disp_valid0,
  output logic [UOP_W-1:0] disp_uop0,
  output logic             disp_valid1,
  output logic [UOP_W-1:0] disp_uop1,
  output logic             illegal_seen,
  output logic             done
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]      stat_dual,
  output logic [31:0]      stat_single,
  output logic [31:0]      stat_stall
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  uop_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic [TAG_W-1:0] r_tag;
  logic             r_adv, r_illegal, r_done;

  logic             w_keep1, w_ill1, w_keep2, w_ill2;
  logic [DEC_W-1:0] w_dec1_raw, w_dec2_raw;
  dec_t             w_dec1, w_dec2, w_first_dec;
  logic             w_wr1, w_wr2;
  logic [CNT_W-1:0] w_nwr, w_npop, w_free, w_count_nxt;
  uop_t             w_first, w_second, w_head0, w_head1;
  unit_e            w_u0, w_u1;
  logic             w_empty;

  instr_decoder u_dec1 (
    .i_instr   (instruction_in1),
    .o_keep    (w_keep1),
    .o_illegal (w_ill1),
    .o_dec     (w_dec1_raw)
  );

  instr_decoder u_dec2 (
    .i_instr   (instruction_in2),
    .o_keep    (w_keep2),
    .o_illegal (w_ill2),
    .o_dec     (w_dec2_raw)
  );

  assign w_dec1 = dec_t'(w_dec1_raw);
  assign w_dec2 = dec_t'(w_dec2_raw);

  // Upstream data is only fresh the cycle after an advance request.
  assign w_wr1 = r_adv & valid_in1 & w_keep1;
  assign w_wr2 = r_adv & valid_in2 & w_keep2;
  assign w_nwr = CNT_W'(w_wr1) + CNT_W'(w_wr2);

  assign w_first_dec = w_wr1 ? w_dec1 : w_dec2;
  assign w_first     = {w_first_dec, UOP_TAG_W'(r_tag)};
  assign w_second    = {w_dec2, UOP_TAG_W'(r_tag + TAG_W'(1))};

  assign w_empty = (r_count == '0);
  assign w_free  = CNT_W'(DEPTH) - r_count;
  // Gated by reset so the request is low while the block is held in reset.
  assign queue_advance = reset & ~queue_empty_in & (w_free >= CNT_W'(4));

  assign w_head0 = r_mem[r_head];
  assign w_head1 = r_mem[r_head + PTR_W'(1)];
  assign w_u0    = unit_of(w_head0.cls);
  assign w_u1    = unit_of(w_head1.cls);

  always_comb begin
    disp_valid0 = ~w_empty & unit_ready(w_u0, alu_ready, mul_ready, mem_ready);
    disp_valid1 = disp_valid0 & (r_count >= CNT_W'(2)) & (w_u1 != w_u0) &
                  unit_ready(w_u1, alu_ready, mul_ready, mem_ready);
    disp_uop0   = disp_valid0 ? w_head0 : '0;
    disp_uop1   = disp_valid1 ? w_head1 : '0;
  end

  assign w_npop      = CNT_W'(disp_valid0) + CNT_W'(disp_valid1);
  assign w_count_nxt = r_count + w_nwr - w_npop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_tag     <= '0;
      r_adv     <= 1'b0;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_adv     <= queue_advance;
      r_head    <= r_head + PTR_W'(w_npop);
      r_tail    <= r_tail + PTR_W'(w_nwr);
      r_count   <= w_count_nxt;
      r_tag     <= r_tag + TAG_W'(w_nwr);
      r_illegal <= r_illegal | (r_adv & ((valid_in1 & w_ill1) | (valid_in2 & w_ill2)));
      r_done    <= r_done | (queue_empty_in & w_empty & ~r_adv);
    end
  end

  always_ff @(posedge clk) begin
    if (w_nwr != '0) r_mem[r_tail] <= w_first;
    if (w_wr1 & w_wr2) r_mem[r_tail + PTR_W'(1)] <= w_second;
  end

  always_ff @(posedge clk) begin
    if (reset) assert (w_count_nxt <= CNT_W'(DEPTH));
  end

  assign illegal_seen = r_illegal;
  assign done         = r_done;

`ifdef DISPATCH_STATS_EN
  logic [31:0] r_stat_dual, r_stat_single, r_stat_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_dual   <= '0;
      r_stat_single <= '0;
      r_stat_stall  <= '0;
    end else if (disp_valid1) begin
      if (r_stat_dual != '1) r_stat_dual <= r_stat_dual + 32'd1;
    end else if (disp_valid0) begin
      if (r_stat_single != '1) r_stat_single <= r_stat_single + 32'd1;
    end else if (!w_empty) begin
      if (r_stat_stall != '1) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_dual   = r_stat_dual;
  assign stat_single = r_stat_single;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_dual_decode_dispatch.sv
// Scoreboard bench for dual_decode_dispatch: directed instruction pairs feed a
// modelled upstream queue; a negedge monitor pops expected uops per dispatch slot.
module tb_dual_decode_dispatch;
  import dispatch_pkg::*;

  typedef struct {
    logic [31:0] i1;
    logic        v1;
    logic [31:0] i2;
    logic        v2;
  } pair_t;

  localparam logic [31:0] I_ADD   = 32'h0020_8033;  // add x0,x1,x2
  localparam logic [31:0] I_ADD2  = 32'h0052_01B3;  // add x3,x4,x5
  localparam logic [31:0] I_MUL   = 32'h0220_8033;  // mul x0,x1,x2
  localparam logic [31:0] I_LOAD  = 32'h0042_A503;  // lw x10,4(x5)
  localparam logic [31:0] I_ST    = 32'h0062_A423;  // sw x6,8(x5)
  localparam logic [31:0] I_ST2   = 32'h7E62_A2A3;  // sw x6,0x7E5(x5)
  localparam logic [31:0] I_NOP   = 32'h0000_0013;
  localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      instruction_in1, instruction_in2;
  logic             valid_in1, valid_in2, queue_empty_in, queue_advance;
  logic             alu_ready, mul_ready, mem_ready;
  logic             disp_valid0, disp_valid1, illegal_seen, done;
  logic [UOP_W-1:0] disp_uop0, disp_uop1;
`ifdef DISPATCH_STATS_EN
  logic [31:0]      stat_dual, stat_single, stat_stall;
`endif

  dual_decode_dispatch #(.DEPTH(8), .TAG_W(6)) dut (
    .clk             (clk),
    .reset           (reset),
    .instruction_in1 (instruction_in1),
    .instruction_in2 (instruction_in2),
    .valid_in1       (valid_in1),
    .valid_in2       (valid_in2),
    .queue_empty_in  (queue_empty_in),
    .queue_advance   (queue_advance),
    .alu_ready       (alu_ready),
    .mul_ready       (mul_ready),
    .mem_ready       (mem_ready),
    .disp_valid0     (disp_valid0),
    .disp_uop0       (disp_uop0),
    .disp_valid1     (disp_valid1),
    .disp_uop1       (disp_uop1),
    .illegal_seen    (illegal_seen),
    .done            (done)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_dual       (stat_dual),
    .stat_single     (stat_single),
    .stat_stall      (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_dual = 0;
  int          n_single = 0;
  uop_t        exp_q[$];
  pair_t       pend_q[$];
  logic [5:0]  exp_tag = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic fail_now(string name, logic [63:0] act);
    n_total++;
    $display("FAIL %s: got %0h, required no dispatch", name, act);
  endtask

  task automatic exp_push(uop_class_e c, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                          logic [11:0] imm);
    uop_t e;
    e.cls = c;
    e.rd  = rd;
    e.rs1 = rs1;
    e.rs2 = rs2;
    e.imm = imm;
    e.tag = exp_tag;
    exp_tag = exp_tag + 6'd1;
    exp_q.push_back(e);
  endtask

  task automatic issue(logic [31:0] i1, logic v1, logic [31:0] i2, logic v2);
    pair_t p;
    p.i1 = i1;
    p.v1 = v1;
    p.i2 = i2;
    p.v2 = v2;
    pend_q.push_back(p);
  endtask

  task automatic wait_drain(string name);
    for (int i = 0; i < 200; i++) begin
      if (pend_q.size() == 0 && exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    check(name, 64'(exp_q.size() + pend_q.size()), 64'd0);
  endtask

  task automatic wait_issued(string name);
    for (int i = 0; i < 100; i++) begin
      if (pend_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, 64'(pend_q.size()), 64'd0);
  endtask

  // Upstream queue model: a fresh pair appears the cycle after an advance request.
  initial begin
    pair_t p;
    logic  adv_s;
    forever begin
      @(negedge clk);
      #4;
      adv_s = queue_advance;
      @(posedge clk);
      #1;
      if (reset && adv_s) begin
        if (pend_q.size() > 0) begin
          p = pend_q.pop_front();
          instruction_in1 = p.i1;
          valid_in1       = p.v1;
          instruction_in2 = p.i2;
          valid_in2       = p.v2;
        end else begin
          valid_in1 = 1'b0;
          valid_in2 = 1'b0;
        end
      end
    end
  end

  // Monitor: every presented uop must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (disp_valid1 && !disp_valid0) fail_now("slot1_without_slot0", 64'(disp_uop1));
      if (disp_valid0) begin
        if (exp_q.size() == 0) fail_now("unexpected_slot0", 64'(disp_uop0));
        else check("slot0_uop", 64'(disp_uop0), 64'(exp_q.pop_front()));
      end
      if (disp_valid1) begin
        if (exp_q.size() == 0) fail_now("unexpected_slot1", 64'(disp_uop1));
        else check("slot1_uop", 64'(disp_uop1), 64'(exp_q.pop_front()));
      end
      if (disp_valid0 && disp_valid1) n_dual++;
      else if (disp_valid0) n_single++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0;
    reset = 1'b0;
    instruction_in1 = '0;
    instruction_in2 = '0;
    valid_in1 = 1'b0;
    valid_in2 = 1'b0;
    queue_empty_in = 1'b0;
    alu_ready = 1'b1;
    mul_ready = 1'b1;
    mem_ready = 1'b1;
    #2;
    check("rst_queue_advance", 64'(queue_advance), 64'd0);
    check("rst_disp_valid0", 64'(disp_valid0), 64'd0);
    check("rst_disp_valid1", 64'(disp_valid1), 64'd0);
    check("rst_disp_uop0", 64'(disp_uop0), 64'd0);
    check("rst_disp_uop1", 64'(disp_uop1), 64'd0);
    check("rst_illegal_seen", 64'(illegal_seen), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // ADD + MUL go out together with tags 0/1.
    d0 = n_dual;
    issue(I_ADD, 1'b1, I_MUL, 1'b1);
    exp_push(ClsAdd, 5'd0, 5'd1, 5'd2, 12'd0);
    exp_push(ClsMul, 5'd0, 5'd1, 5'd2, 12'd0);
    wait_drain("drain_addmul");
    check("addmul_dual_cycles", 64'(n_dual - d0), 64'd1);

    // Two ALU uops serialise through slot0.
    d0 = n_dual;
    s0 = n_single;
    issue(I_ADD, 1'b1, I_ADD2, 1'b1);
    exp_push(ClsAdd, 5'd0, 5'd1, 5'd2, 12'd0);
    exp_push(ClsAdd, 5'd3, 5'd4, 5'd5, 12'd0);
    wait_drain("drain_addadd");
    check("addadd_dual_cycles", 64'(n_dual - d0), 64'd0);
    check("addadd_single_cycles", 64'(n_single - s0), 64'd2);

    // LOAD + NOP, then two stores; the NOP takes no tag.
    issue(I_LOAD, 1'b1, I_NOP, 1'b1);
    exp_push(ClsLoad, 5'd10, 5'd5, 5'd4, 12'd4);
    issue(I_ST, 1'b1, I_ST2, 1'b1);
    exp_push(ClsStore, 5'd8, 5'd5, 5'd6, 12'd8);
    exp_push(ClsStore, 5'd5, 5'd5, 5'd6, 12'h7E5);
    wait_drain("drain_loadstore");

    // Memory stall holds everything behind the LOAD; FIFO fills to 6.
    @(posedge clk);
    #1 mem_ready = 1'b0;
    issue(I_LOAD, 1'b1, I_ADD2, 1'b1);
    exp_push(ClsLoad, 5'd10, 5'd5, 5'd4, 12'd4);
    exp_push(ClsAdd, 5'd3, 5'd4, 5'd5, 12'd0);
    issue(I_MUL, 1'b1, I_ADD, 1'b1);
    exp_push(ClsMul, 5'd0, 5'd1, 5'd2, 12'd0);
    exp_push(ClsAdd, 5'd0, 5'd1, 5'd2, 12'd0);
    issue(I_ADD, 1'b1, I_MUL, 1'b1);
    exp_push(ClsAdd, 5'd0, 5'd1, 5'd2, 12'd0);
    exp_push(ClsMul, 5'd0, 5'd1, 5'd2, 12'd0);
    wait_issued("stall_pairs_issued");
    repeat (3) @(negedge clk);
    // Stale upstream data with valid high must not be captured.
    @(posedge clk);
    #1;
    instruction_in1 = I_ADD;
    instruction_in2 = I_MUL;
    valid_in1 = 1'b1;
    valid_in2 = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("stall_queue_advance", 64'(queue_advance), 64'd0);
    check("stall_disp_valid0", 64'(disp_valid0), 64'd0);
    d0 = n_dual;
    @(posedge clk);
    #1;
    valid_in1 = 1'b0;
    valid_in2 = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("unstall_slot0", 64'(disp_valid0), 64'd1);
    check("unstall_slot1", 64'(disp_valid1), 64'd1);
    wait_drain("drain_stall");
    check("stall_dual_cycles", 64'(n_dual - d0), 64'd3);

    // Illegal word dropped and flagged; valid_in2 low suppresses its slot.
    check("illegal_before", 64'(illegal_seen), 64'd0);
    issue(I_BAD, 1'b1, I_ADD2, 1'b1);
    exp_push(ClsAdd, 5'd3, 5'd4, 5'd5, 12'd0);
    issue(I_MUL, 1'b1, I_ADD, 1'b0);
    exp_push(ClsMul, 5'd0, 5'd1, 5'd2, 12'd0);
    wait_drain("drain_illegal");
    check("illegal_after", 64'(illegal_seen), 64'd1);

    // Upstream empty and FIFO drained -> done.
    check("done_before", 64'(done), 64'd0);
    @(posedge clk);
    #1 queue_empty_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("done_after", 64'(done), 64'd1);
    check("empty_queue_advance", 64'(queue_advance), 64'd0);

    // Fill 5 ALU entries with the ALU blocked, then reset mid-stream.
    @(posedge clk);
    #1;
    queue_empty_in = 1'b0;
    alu_ready = 1'b0;
    issue(I_ADD, 1'b1, I_ADD2, 1'b1);
    issue(I_ADD2, 1'b1, I_ADD, 1'b1);
    issue(I_ADD, 1'b1, I_NOP, 1'b1);
    wait_issued("fill5_issued");
    repeat (4) @(negedge clk);
    #1;
    check("fill5_queue_advance", 64'(queue_advance), 64'd0);
    check("fill5_disp_valid0", 64'(disp_valid0), 64'd0);
    @(posedge clk);
    #1;
    alu_ready = 1'b1;
    reset = 1'b0;
    valid_in1 = 1'b0;
    valid_in2 = 1'b0;
    pend_q.delete();
    exp_q.delete();
    exp_tag = '0;
    #1;
    check("midrst_disp_valid0", 64'(disp_valid0), 64'd0);
    check("midrst_disp_uop0", 64'(disp_uop0), 64'd0);
    check("midrst_queue_advance", 64'(queue_advance), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_illegal", 64'(illegal_seen), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    issue(I_ADD, 1'b1, I_MUL, 1'b1);
    exp_push(ClsAdd, 5'd0, 5'd1, 5'd2, 12'd0);
    exp_push(ClsMul, 5'd0, 5'd1, 5'd2, 12'd0);
    wait_drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
